// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit.
// All outputs are registered; a single FSM drives line, busy and done.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_serial
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DATA_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               state_q;
  logic [CntW-1:0]      baud_q;
  logic [IdxW-1:0]      bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;

  logic            baud_wrap;
  logic [IdxW-1:0] bit_idx_nxt;

  // Bit-period end and the index of the following data bit.
  always_comb begin
    baud_wrap   = (baud_q == CntMax);
    bit_idx_nxt = bit_idx_q + IdxW'(1);
  end

  // Frame sequencer; the latched word is held unchanged and indexed, never shifted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          baud_q    <= '0;
          bit_idx_q <= '0;
          tx_serial <= 1'b1;
          tx_busy   <= 1'b0;
          if (tx_start) begin
            state_q   <= StStart;
            shift_q   <= tx_data;
            tx_serial <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end
        StStart: begin
          if (baud_wrap) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= StData;
            tx_serial <= shift_q[0];
          end else begin
            baud_q <= baud_q + CntW'(1);
          end
        end
        StData: begin
          if (baud_wrap) begin
            baud_q <= '0;
            if (bit_idx_q == IdxMax) begin
              state_q   <= StStop;
              tx_serial <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_nxt;
              tx_serial <= shift_q[bit_idx_nxt];
            end
          end else begin
            baud_q <= baud_q + CntW'(1);
          end
        end
        StStop: begin
          if (baud_wrap) begin
            baud_q    <= '0;
            state_q   <= StIdle;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            // Done coincides with the first idle cycle, where a new start can be taken.
            tx_done   <= 1'b1;
          end else begin
            baud_q <= baud_q + CntW'(1);
          end
        end
        default: begin
          state_q   <= StIdle;
          tx_serial <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a default-size instance (4 clks/bit, 8 bits)
// and a small one (2 clks/bit, 5 bits). Expected frames are hand-written bit
// vectors (bit 0 = first bit on the line) pushed before each stimulus.
module tb_uart_tx;

  typedef struct {
    logic [9:0] frame;
    int         nbits;
    int         abort_at;  // 0 = full frame, else frame cycle index seen after reset
    bit         b2b;       // must start exactly one cycle after the previous done
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_a, start_a, busy_a, done_a, ser_a;
  logic [7:0] data_a;
  logic       reset_b, start_b, busy_b, done_b, ser_b;
  logic [4:0] data_b;

  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   n_done_a = 0;
  int   n_done_b = 0;
  int   last_done[2];
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_a === 1'b1) n_done_a <= n_done_a + 1;
    if (done_b === 1'b1) n_done_b <= n_done_b + 1;
  end

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) u_dut_a (
    .clk       (clk),
    .reset     (reset_a),
    .tx_data   (data_a),
    .tx_start  (start_a),
    .tx_busy   (busy_a),
    .tx_done   (done_a),
    .tx_serial (ser_a)
  );

  uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5)) u_dut_b (
    .clk       (clk),
    .reset     (reset_b),
    .tx_data   (data_b),
    .tx_start  (start_b),
    .tx_busy   (busy_b),
    .tx_done   (done_b),
    .tx_serial (ser_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic get_ser(input int id);
    return (id == 0) ? ser_a : ser_b;
  endfunction

  function automatic logic get_busy(input int id);
    return (id == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic get_done(input int id);
    return (id == 0) ? done_a : done_b;
  endfunction

  // Monitor: on busy rising, pop the expected frame and check every cycle of it.
  task automatic monitor(input int id);
    exp_t e;
    int   c;
    int   qs;
    bit   aborted;
    c = (id == 0) ? 4 : 2;
    forever begin
      @(negedge clk);
      if (get_busy(id) === 1'b1) begin
        qs = (id == 0) ? q_a.size() : q_b.size();
        if (qs == 0) begin
          check($sformatf("unexpected_frame id%0d cyc%0d", id, cyc), 1, 0);
          for (int i = 0; i < 200 && get_busy(id) === 1'b1; i++) @(negedge clk);
        end else begin
          e = (id == 0) ? q_a.pop_front() : q_b.pop_front();
          if (e.b2b) check($sformatf("b2b_gap id%0d", id), cyc - last_done[id], 1);
          aborted = 1'b0;
          for (int k = 0; k < e.nbits * c; k++) begin
            if (e.abort_at != 0 && k == e.abort_at) begin
              check($sformatf("abort_serial id%0d", id), get_ser(id), 1'b1);
              check($sformatf("abort_busy id%0d", id), get_busy(id), 1'b0);
              check($sformatf("abort_done id%0d", id), get_done(id), 1'b0);
              aborted = 1'b1;
              break;
            end
            check($sformatf("serial id%0d frame%0h k%0d", id, e.frame, k), get_ser(id),
                  e.frame[k / c]);
            check($sformatf("busy id%0d frame%0h k%0d", id, e.frame, k), get_busy(id), 1'b1);
            @(negedge clk);
          end
          if (!aborted) begin
            check($sformatf("done id%0d frame%0h", id, e.frame), get_done(id), 1'b1);
            check($sformatf("done_busy id%0d frame%0h", id, e.frame), get_busy(id), 1'b0);
            check($sformatf("done_serial id%0d frame%0h", id, e.frame), get_ser(id), 1'b1);
            last_done[id] = cyc;
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // One-cycle start pulse; returns #1 after the accepting edge (frame cycle 1).
  task automatic send_a(input logic [7:0] d);
    data_a  = d;
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
  endtask

  task automatic send_b(input logic [4:0] d);
    data_b  = d;
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
  endtask

  task automatic wait_idle(input int id);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (get_busy(id) === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check($sformatf("wait_idle_timeout id%0d", id), 1, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    last_done[0] = 0;
    last_done[1] = 0;
    reset_a = 1'b1; start_a = 1'b0; data_a = '0;
    reset_b = 1'b1; start_b = 1'b0; data_b = '0;
    repeat (3) @(posedge clk);
    #1 reset_a = 1'b0; reset_b = 1'b0;
    @(negedge clk);
    check("reset_serial_a", ser_a, 1'b1);
    check("reset_busy_a", busy_a, 1'b0);
    check("reset_done_a", done_a, 1'b0);
    check("reset_serial_b", ser_b, 1'b1);
    check("reset_busy_b", busy_b, 1'b0);
    check("reset_done_b", done_b, 1'b0);

    // 0xA5: line 0,1,0,1,0,0,1,0,1,1
    q_a.push_back('{10'b1101001010, 10, 0, 1'b0});
    send_a(8'hA5);
    wait_idle(0);

    // 0x3C with a 0xFF start request in frame cycle 10 that must be ignored
    q_a.push_back('{10'b1001111000, 10, 0, 1'b0});
    send_a(8'h3C);
    repeat (9) @(posedge clk);
    #1 data_a = 8'hFF; start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    wait_idle(0);

    // 0x00 then 0xFF requested in the done cycle
    q_a.push_back('{10'b1000000000, 10, 0, 1'b0});
    q_a.push_back('{10'b1111111110, 10, 0, 1'b1});
    send_a(8'h00);
    repeat (40) @(posedge clk);
    #1 send_a(8'hFF);
    wait_idle(0);

    // 0x55 aborted by reset in frame cycle 17, then 0x81
    q_a.push_back('{10'b1010101010, 10, 17, 1'b0});
    send_a(8'h55);
    repeat (16) @(posedge clk);
    #1 reset_a = 1'b1;
    @(posedge clk);
    #1 reset_a = 1'b0;
    wait_idle(0);
    q_a.push_back('{10'b1100000010, 10, 0, 1'b0});
    send_a(8'h81);
    wait_idle(0);

    // Reset and start together: nothing may be accepted
    reset_a = 1'b1; start_a = 1'b1; data_a = 8'hA5;
    @(posedge clk);
    #1 reset_a = 1'b0; start_a = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (ser_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    check("reset_with_start_bad_cycles", bad, 0);

    // Small instance: 0x1B over 5 bits -> 0,1,1,0,1,1,1
    q_b.push_back('{10'b0001110110, 7, 0, 1'b0});
    send_b(5'h1B);
    wait_idle(1);

    repeat (5) @(negedge clk);
    check("queue_a_empty", q_a.size(), 0);
    check("queue_b_empty", q_b.size(), 0);
    check("done_pulses_a", n_done_a, 5);
    check("done_pulses_b", n_done_b, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
